if_stage: RTL and testbench

IF_STAGE -- requirements
Module: if_stage

---
 rtl/if_stage.sv | 123 ++++++++++++
 tb/tb_if_stage.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
`default_nettype none
// ============================================================================
// Module  : if_stage
// Purpose : Instruction fetch stage with IF/ID register and redirect handling.
// Revision: 1.0
// ============================================================================
module if_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic        stall_i,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_ready_i,
   input  logic [31:0] imem_data_i,
   output logic [31:0] instr_o,
   output logic [31:0] pc_o,
   output logic [31:0] pc_plus4_o,
   output logic        valid_o
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_KILL  = 2'd2
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic [31:0] r_pc_q;
   logic [31:0] w_pc_nxt;
   logic [31:0] r_kill_addr;
   logic [31:0] w_kill_nxt;
   logic [31:0] r_instr;
   logic [31:0] w_instr_nxt;
   logic [31:0] r_pc_o;
   logic [31:0] w_pc_o_nxt;
   logic        r_valid;
   logic        w_valid_nxt;
   logic [31:0] w_redir_target;

   assign w_redir_target = redirect_pc_i & 32'hFFFF_FFFC;

   always_comb begin
      w_state_nxt = r_state;
      w_pc_nxt    = r_pc_q;
      w_kill_nxt  = r_kill_addr;
      w_instr_nxt = r_instr;
      w_pc_o_nxt  = r_pc_o;
      w_valid_nxt = r_valid;
      case (r_state)
         S_IDLE: begin
            w_state_nxt = S_FETCH;
         end
         S_FETCH: begin
            if (redirect_i) begin
               w_pc_nxt    = w_redir_target;
               w_valid_nxt = 1'b0;
               w_instr_nxt = NOP_INSTR;
               // Outstanding request must complete at its original address.
               if (!imem_ready_i) begin
                  w_kill_nxt  = r_pc_q;
                  w_state_nxt = S_KILL;
               end
            end else if (!stall_i) begin
               if (imem_ready_i) begin
                  w_instr_nxt = imem_data_i;
                  w_pc_o_nxt  = r_pc_q;
                  w_valid_nxt = 1'b1;
                  w_pc_nxt    = r_pc_q + 32'd4;
               end else begin
                  w_instr_nxt = NOP_INSTR;
                  w_valid_nxt = 1'b0;
               end
            end
         end
         S_KILL: begin
            if (redirect_i) begin
               w_pc_nxt    = w_redir_target;
               w_valid_nxt = 1'b0;
               w_instr_nxt = NOP_INSTR;
            end
            if (imem_ready_i) begin
               w_state_nxt = S_FETCH;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         r_state     <= S_IDLE;
         r_pc_q      <= RESET_PC;
         r_kill_addr <= 32'd0;
         r_instr     <= NOP_INSTR;
         r_pc_o      <= 32'd0;
         r_valid     <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_pc_q      <= w_pc_nxt;
         r_kill_addr <= w_kill_nxt;
         r_instr     <= w_instr_nxt;
         r_pc_o      <= w_pc_o_nxt;
         r_valid     <= w_valid_nxt;
      end
   end

   assign imem_req_o  = (r_state != S_IDLE);
   assign imem_addr_o = (r_state == S_KILL) ? r_kill_addr : r_pc_q;
   assign instr_o     = r_instr;
   assign pc_o        = r_pc_o;
   assign pc_plus4_o  = r_pc_o + 32'd4;
   assign valid_o     = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_if_stage.sv
`default_nettype none
// ============================================================================
// Module  : tb_if_stage
// Purpose : Directed and randomized checks of if_stage against a cycle model.
// Revision: 1.0
// ============================================================================
module tb_if_stage;

   localparam logic [31:0] C_RESET_PC = 32'h0000_0000;
   localparam logic [31:0] C_NOP      = 32'h0000_0013;

   logic        clk;
   logic        rst_n;
   logic        stall;
   logic        redir;
   logic [31:0] redir_pc;
   logic        req;
   logic [31:0] addr;
   logic        ready;
   logic [31:0] data;
   logic [31:0] instr;
   logic [31:0] pc;
   logic [31:0] pc4;
   logic        valid;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: fetch-stream view of the stage.
   logic        m_started;
   logic        m_pend;
   logic [31:0] m_kaddr;
   logic [31:0] m_pc;
   logic        m_valid;
   logic [31:0] m_instr;
   logic [31:0] m_pco;

   if_stage #(
      .RESET_PC  (C_RESET_PC),
      .NOP_INSTR (C_NOP)
   ) dut (
      .clk_i         (clk),
      .rst_n_i       (rst_n),
      .stall_i       (stall),
      .redirect_i    (redir),
      .redirect_pc_i (redir_pc),
      .imem_req_o    (req),
      .imem_addr_o   (addr),
      .imem_ready_i  (ready),
      .imem_data_i   (data),
      .instr_o       (instr),
      .pc_o          (pc),
      .pc_plus4_o    (pc4),
      .valid_o       (valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] mem(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s got=%08h exp=%08h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input logic i_rst_n, input logic i_stall, input logic i_redir,
                      input logic [31:0] i_rpc, input logic i_ready);
      logic [31:0] issued;
      issued   = m_pend ? m_kaddr : m_pc;
      rst_n    = i_rst_n;
      stall    = i_stall;
      redir    = i_redir;
      redir_pc = i_rpc;
      ready    = i_ready;
      data     = i_ready ? mem(issued) : $urandom;
      @(posedge clk);
      if (!i_rst_n) begin
         m_started = 1'b0; m_pend = 1'b0; m_kaddr = 32'd0; m_pc = C_RESET_PC;
         m_valid = 1'b0; m_instr = C_NOP; m_pco = 32'd0;
      end else if (!m_started) begin
         m_started = 1'b1;
      end else if (i_redir) begin
         if (!m_pend && !i_ready) begin
            m_pend  = 1'b1;
            m_kaddr = m_pc;
         end else if (m_pend && i_ready) begin
            m_pend = 1'b0;
         end
         m_pc    = {i_rpc[31:2], 2'b00};
         m_valid = 1'b0;
         m_instr = C_NOP;
      end else if (m_pend) begin
         if (i_ready) m_pend = 1'b0;
      end else if (!i_stall) begin
         if (i_ready) begin
            m_instr = mem(m_pc);
            m_pco   = m_pc;
            m_valid = 1'b1;
            m_pc    = m_pc + 32'd4;
         end else begin
            m_valid = 1'b0;
            m_instr = C_NOP;
         end
      end
      #1;
      chk("req",   {31'd0, req},   {31'd0, m_started});
      chk("valid", {31'd0, valid}, {31'd0, m_valid});
      chk("instr", instr, m_instr);
      chk("pc",    pc,    m_pco);
      chk("pc4",   pc4,   m_pco + 32'd4);
      if (m_started) chk("addr", addr, m_pend ? m_kaddr : m_pc);
   endtask

   initial begin
      logic        r_rst_n;
      logic        r_st;
      logic        r_rd;
      logic [31:0] r_rpc;
      logic        r_rdy;
      m_started = 1'b0; m_pend = 1'b0; m_kaddr = 32'd0; m_pc = C_RESET_PC;
      m_valid = 1'b0; m_instr = C_NOP; m_pco = 32'd0;
      rst_n = 1'b0; stall = 1'b0; redir = 1'b0; redir_pc = 32'd0; ready = 1'b0; data = 32'd0;

      // Reset state, with stall and redirect asserted to confirm reset wins
      cyc(1'b0, 1'b1, 1'b1, 32'h100, 1'b1);
      cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
      chk("rst_pc4", pc4, 32'd4);
      chk("rst_req", {31'd0, req}, 32'd0);

      // Zero-wait stream
      cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
      chk("z_req1", {31'd0, req}, 32'd1);
      chk("z_val1", {31'd0, valid}, 32'd0);
      cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
      chk("z_pc0", pc, 32'h0);
      chk("z_w0", instr, mem(32'h0));
      cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
      cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
      chk("z_pc8", pc, 32'h8);

      // Stall three cycles while pc_o=8
      for (int i = 0; i < 3; i++) begin
         cyc(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
         chk("st_pc", pc, 32'h8);
         chk("st_addr", addr, 32'hC);
      end
      cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
      chk("st_rel", pc, 32'hC);

      // Redirect with request outstanding at 0x10
      cyc(1'b1, 1'b0, 1'b1, 32'h203, 1'b0);
      chk("k_addr0", addr, 32'h10);
      cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
      chk("k_addr1", addr, 32'h10);
      chk("k_val", {31'd0, valid}, 32'd0);
      cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
      chk("k_new", addr, 32'h200);
      chk("k_val2", {31'd0, valid}, 32'd0);
      cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
      chk("k_pc", pc, 32'h200);

      // Redirect and stall together
      cyc(1'b1, 1'b1, 1'b1, 32'h40, 1'b1);
      chk("rs_val", {31'd0, valid}, 32'd0);
      cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
      chk("rs_pc", pc, 32'h40);

      // PC wrap
      cyc(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1);
      cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
      chk("w_pc", pc, 32'hFFFF_FFFC);
      chk("w_pc4", pc4, 32'h0);
      cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
      chk("w_pc0", pc, 32'h0);

      // Reset while in KILL
      cyc(1'b1, 1'b0, 1'b1, 32'h80, 1'b0);
      cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      chk("rk_req", {31'd0, req}, 32'd0);
      chk("rk_val", {31'd0, valid}, 32'd0);
      cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
      chk("rk_addr", addr, C_RESET_PC);
      cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
      chk("rk_pc", pc, C_RESET_PC);

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         r_rst_n = ($urandom_range(0, 63) != 0);
         r_st    = ($urandom_range(0, 3) == 0);
         r_rd    = ($urandom_range(0, 7) == 0);
         r_rpc   = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 15)))
                                               : 32'($urandom);
         r_rdy   = ($urandom_range(0, 2) != 0);
         cyc(r_rst_n, r_st, r_rd, r_rpc, r_rdy);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
